// File: rtl/boss_hp.sv
// boss_hp: boss health, phase and death tracker with a thermometer health bar.
// Optional slow regeneration in the last phase when BOSS_REGEN_EN is defined.
`timescale 1ns/1ps
module boss_hp #(
    parameter int HP_MAX     = 500,
    parameter int HP_W       = 10,
    parameter int HIT_DMG    = 1,
    parameter int BOMB_DMG   = 10,
    parameter int BOMB_TICK  = 1_000_000,
    parameter int PHASE2_HP  = 250,
    parameter int PHASE3_HP  = 100,
    parameter int PHASE_INV  = 50_000_000,
    parameter int REGEN_TICK = 25_000_000
) (
    input  logic            clk,
    input  logic            hard_reset,
    input  logic            game_reset,
    input  logic            game_en,
    input  logic [3:0]      game_state,
    input  logic            hit,
    output logic [HP_W-1:0] hp,
    output logic [1:0]      phase,
    output logic            die,
    output logic [7:0]      hp_bar
);
    localparam int BOMB_W = BOMB_TICK > 1 ? $clog2(BOMB_TICK) : 1;
    localparam int INV_W  = PHASE_INV > 1 ? $clog2(PHASE_INV) : 1;
    localparam logic [3:0] GS_BOMB = 4'b0110;

    typedef enum logic [1:0] {IDLE, FIGHT, TRANS, DEAD} state_t;

    state_t            state_q, state_d;
    logic [HP_W-1:0]   hp_q, hp_d;
    logic [1:0]        phase_q, phase_d;
    logic              die_q, die_d;
    logic [7:0]        hp_bar_q, hp_bar_d;
    logic              hit_q, hit_d;
    logic [BOMB_W-1:0] bomb_cnt_q, bomb_cnt_d;
    logic [INV_W-1:0]  inv_cnt_q, inv_cnt_d;
`ifdef BOSS_REGEN_EN
    localparam int REGEN_W = REGEN_TICK > 1 ? $clog2(REGEN_TICK) : 1;
    logic [REGEN_W-1:0] regen_cnt_q, regen_cnt_d;
`endif

    logic        hit_edge, bomb_on, bomb_tick;
    logic [31:0] dmg, hp_new;
    logic [1:0]  phase_raw, phase_new;

    always_comb begin
        hit_edge  = hit & ~hit_q;
        bomb_on   = state_q == FIGHT && game_en && game_state == GS_BOMB;
        bomb_tick = bomb_on && bomb_cnt_q == BOMB_W'(BOMB_TICK - 1);
        dmg       = (hit_edge ? 32'(HIT_DMG) : 32'd0) + (bomb_tick ? 32'(BOMB_DMG) : 32'd0);
        hp_new    = 32'(hp_q) > dmg ? 32'(hp_q) - dmg : 32'd0;
        phase_raw = hp_new <= 32'(PHASE3_HP) ? 2'd2 : hp_new <= 32'(PHASE2_HP) ? 2'd1 : 2'd0;
        phase_new = phase_raw > phase_q ? phase_raw : phase_q;
        state_d    = state_q;
        hp_d       = hp_q;
        phase_d    = phase_q;
        die_d      = die_q;
        hit_d      = hit;
        bomb_cnt_d = bomb_on && !bomb_tick ? bomb_cnt_q + BOMB_W'(1) : '0;
        inv_cnt_d  = '0;
        // bar bit i lights while hp is above i/8 of full health
        for (int i = 0; i < 8; i++)
            hp_bar_d[i] = (32'(hp_q) << 3) > 32'(i * HP_MAX);
        case (state_q)
            IDLE: if (game_en) state_d = FIGHT;
            FIGHT: begin
                if (!game_en) begin
                    state_d = IDLE;
                end else if (dmg != 32'd0) begin
                    hp_d    = HP_W'(hp_new);
                    phase_d = phase_new;
                    if (hp_new == 32'd0) begin
                        state_d = DEAD;
                        die_d   = 1'b1;
                    end else if (phase_new != phase_q) begin
                        state_d = TRANS;
                    end
                end
            end
            TRANS: begin
                inv_cnt_d = inv_cnt_q + INV_W'(1);
                if (inv_cnt_q == INV_W'(PHASE_INV - 1)) begin
                    state_d   = FIGHT;
                    inv_cnt_d = '0;
                end
            end
            default: ;
        endcase
`ifdef BOSS_REGEN_EN
        regen_cnt_d = '0;
        if (state_q == FIGHT && game_en && phase_q == 2'd2 && dmg == 32'd0) begin
            regen_cnt_d = regen_cnt_q + REGEN_W'(1);
            if (regen_cnt_q == REGEN_W'(REGEN_TICK - 1)) begin
                regen_cnt_d = '0;
                if (hp_q < HP_W'(PHASE3_HP)) hp_d = hp_q + HP_W'(1);
            end
        end
`endif
        if (game_reset) begin
            state_d    = IDLE;
            hp_d       = HP_W'(HP_MAX);
            phase_d    = 2'd0;
            die_d      = 1'b0;
            hp_bar_d   = 8'hFF;
            hit_d      = 1'b0;
            bomb_cnt_d = '0;
            inv_cnt_d  = '0;
`ifdef BOSS_REGEN_EN
            regen_cnt_d = '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge hard_reset) begin
        if (hard_reset) begin
            state_q    <= IDLE;
            hp_q       <= HP_W'(HP_MAX);
            phase_q    <= 2'd0;
            die_q      <= 1'b0;
            hp_bar_q   <= 8'hFF;
            hit_q      <= 1'b0;
            bomb_cnt_q <= '0;
            inv_cnt_q  <= '0;
`ifdef BOSS_REGEN_EN
            regen_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            hp_q       <= hp_d;
            phase_q    <= phase_d;
            die_q      <= die_d;
            hp_bar_q   <= hp_bar_d;
            hit_q      <= hit_d;
            bomb_cnt_q <= bomb_cnt_d;
            inv_cnt_q  <= inv_cnt_d;
`ifdef BOSS_REGEN_EN
            regen_cnt_q <= regen_cnt_d;
`endif
        end
    end

    assign hp     = hp_q;
    assign phase  = phase_q;
    assign die    = die_q;
    assign hp_bar = hp_bar_q;
endmodule
